// File: rtl/divider_pkg.sv
// Shared state encoding and default parameters for the divider memory read controller.
package divider_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StIssue    = 2'd1,
    StDrain    = 2'd2,
    StComplete = 2'd3
  } state_e;

  localparam int unsigned DefAddrW    = 16;
  localparam int unsigned DefCntW     = 7;
  localparam int unsigned DefMaxOutst = 2;
  // Wide enough for the largest legal MAX_OUTST (7).
  localparam int unsigned CreditW     = 3;

endpackage

// File: rtl/divider_credit_cnt.sv
// Outstanding-read credit counter: bounded between 0 and MAX_OUTST, inc and dec cancel.
module divider_credit_cnt
  import divider_pkg::*;
#(
  parameter int unsigned MAX_OUTST = DefMaxOutst
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  input  logic               dec,
  output logic [CreditW-1:0] count,
  output logic               zero,
  output logic               full
);

  localparam logic [CreditW-1:0] MaxCnt = CreditW'(MAX_OUTST);

  logic [CreditW-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (inc && !dec && !full) begin
      count_q <= count_q + CreditW'(1);
    end else if (dec && !inc && !zero) begin
      count_q <= count_q - CreditW'(1);
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);
  assign full  = (count_q == MaxCnt);

endmodule

// File: rtl/divider_mem_rd_ctrl.sv
// Issues strided memory reads to feed the divider, throttled by div_done credits,
// with abort/drain handling and sticky status flags.
module divider_mem_rd_ctrl
  import divider_pkg::*;
#(
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned CNT_W     = DefCntW,
  parameter int unsigned MAX_OUTST = DefMaxOutst
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_stride,
  input  logic [CNT_W-1:0]  cfg_lines,
  input  logic              div_done,
  output logic [ADDR_W-1:0] sc_mem_rdaddr,
  output logic              sc_mem_rd_en,
  output logic              sc_mem_rd_done,
  output logic              busy,
  output logic              aborted,
  output logic              err_unexp_done,
  output logic [CNT_W-1:0]  lines_issued
);

  state_e             state_q;
  logic [ADDR_W-1:0]  addr_q, stride_q, rdaddr_q;
  logic [CNT_W-1:0]   lines_q, issued_q;
  logic               rd_en_q, rd_done_q, aborted_q, err_q;

  logic [CreditW-1:0] outs, outs_next;
  logic               outs_zero, outs_full;
  logic               dec, unexp, issue;

  always_comb begin
    dec       = div_done && !outs_zero;
    unexp     = div_done && outs_zero;
    outs_next = outs - CreditW'(dec);
    // A returning credit in the same cycle frees a slot even when the counter is full.
    issue     = (state_q == StIssue) && !abort && (issued_q < lines_q) && (!outs_full || dec);
  end

  divider_credit_cnt #(
    .MAX_OUTST(MAX_OUTST)
  ) u_credit (
    .clk  (clk),
    .reset(reset),
    .inc  (issue),
    .dec  (dec),
    .count(outs),
    .zero (outs_zero),
    .full (outs_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      stride_q  <= '0;
      rdaddr_q  <= '0;
      lines_q   <= '0;
      issued_q  <= '0;
      rd_en_q   <= 1'b0;
      rd_done_q <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rd_en_q   <= 1'b0;
      rd_done_q <= 1'b0;
      if (unexp) err_q <= 1'b1;
      case (state_q)
        StIdle: begin
          if (start) begin
            addr_q    <= cfg_base;
            stride_q  <= cfg_stride;
            lines_q   <= cfg_lines;
            issued_q  <= '0;
            aborted_q <= 1'b0;
            err_q     <= unexp;
            state_q   <= StIssue;
          end
        end
        StIssue: begin
          if (abort) begin
            aborted_q <= 1'b1;
            state_q   <= StDrain;
          end else if (issued_q == lines_q) begin
            if (outs_next == '0) begin
              rd_done_q <= 1'b1;
              state_q   <= StComplete;
            end else begin
              state_q <= StDrain;
            end
          end else if (issue) begin
            rd_en_q  <= 1'b1;
            rdaddr_q <= addr_q;
            addr_q   <= addr_q + stride_q;
            issued_q <= issued_q + CNT_W'(1);
          end
        end
        StDrain: begin
          if (outs_next == '0) begin
            rd_done_q <= 1'b1;
            state_q   <= StComplete;
          end
        end
        StComplete: state_q <= StIdle;
        default:    state_q <= StIdle;
      endcase
    end
  end

  assign sc_mem_rdaddr  = rdaddr_q;
  assign sc_mem_rd_en   = rd_en_q;
  assign sc_mem_rd_done = rd_done_q;
  assign busy           = (state_q != StIdle);
  assign aborted        = aborted_q;
  assign err_unexp_done = err_q;
  assign lines_issued   = issued_q;

endmodule

// File: tb/tb_divider_mem_rd_ctrl.sv
// Scoreboard bench for divider_mem_rd_ctrl: stimulus pushes expected reads/completions,
// a negedge monitor pops and compares; a responder returns div_done after a delay.
module tb_divider_mem_rd_ctrl;

  typedef struct packed {
    logic       ab;
    logic [6:0] lines;
  } done_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] cfg_base = '0;
  logic [15:0] cfg_stride = '0;
  logic [6:0]  cfg_lines = '0;
  logic        man_done = 1'b0;
  logic        rsp_done;
  logic        div_done;
  logic [15:0] sc_mem_rdaddr;
  logic        sc_mem_rd_en;
  logic        sc_mem_rd_done;
  logic        busy;
  logic        aborted;
  logic        err_unexp_done;
  logic [6:0]  lines_issued;

  assign div_done = man_done | rsp_done;

  logic [15:0] exp_addr[$];
  done_t       exp_done[$];
  int          due_q[$];
  int          checks = 0;
  int          errors = 0;
  int          rd_cnt = 0;
  int          done_cnt = 0;
  int          seq_rd = 0;
  int          seq_dn = 0;
  int          cyc = 0;
  int          rsp_delay = 3;
  bit          hold = 1'b0;
  bit          flush = 1'b0;

  always #5 clk = ~clk;

  divider_mem_rd_ctrl #(
    .ADDR_W   (16),
    .CNT_W    (7),
    .MAX_OUTST(2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .cfg_base      (cfg_base),
    .cfg_stride    (cfg_stride),
    .cfg_lines     (cfg_lines),
    .div_done      (div_done),
    .sc_mem_rdaddr (sc_mem_rdaddr),
    .sc_mem_rd_en  (sc_mem_rd_en),
    .sc_mem_rd_done(sc_mem_rd_done),
    .busy          (busy),
    .aborted       (aborted),
    .err_unexp_done(err_unexp_done),
    .lines_issued  (lines_issued)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Divider model: one div_done per issued read, rsp_delay cycles later, unless held.
  initial begin
    rsp_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (flush) due_q.delete();
      if (sc_mem_rd_en) due_q.push_back(cyc + rsp_delay);
      if (!hold && due_q.size() > 0 && due_q[0] <= cyc) begin
        void'(due_q.pop_front());
        rsp_done = 1'b1;
      end else begin
        rsp_done = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (sc_mem_rd_en) begin
        rd_cnt++;
        seq_rd++;
        if (exp_addr.size() == 0) begin
          check("rd_en_unexpected", 32'd1, 32'd0);
        end else begin
          check("rdaddr", {16'd0, sc_mem_rdaddr}, {16'd0, exp_addr.pop_front()});
        end
      end
      if (div_done && busy) seq_dn++;
      if (sc_mem_rd_done) begin
        done_t e;
        done_cnt++;
        if (exp_done.size() == 0) begin
          check("rd_done_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_done.pop_front();
          check("aborted", {31'd0, aborted}, {31'd0, e.ab});
          check("lines_issued", {25'd0, lines_issued}, {25'd0, e.lines});
          check("done_after_drain", seq_dn, seq_rd);
        end
      end
      if (!busy) begin
        seq_rd = 0;
        seq_dn = 0;
      end
    end
  end

  task automatic expect_seq(input logic [15:0] base, input logic [15:0] stride, input int n,
                            input logic ab, input int nl);
    logic [15:0] a;
    done_t d;
    a = base;
    for (int k = 0; k < n; k++) begin
      exp_addr.push_back(a);
      a = a + stride;
    end
    d.ab = ab;
    d.lines = 7'(nl);
    exp_done.push_back(d);
  endtask

  // Called in the posedge+1 phase; start is sampled on the next edge.
  task automatic start_seq(input logic [15:0] base, input logic [15:0] stride,
                           input logic [6:0] lines);
    start = 1'b1;
    cfg_base = base;
    cfg_stride = stride;
    cfg_lines = lines;
    @(posedge clk);
    #1;
    start = 1'b0;
    cfg_base = 16'hDEAD;
    cfg_stride = 16'h0123;
    cfg_lines = 7'd99;
  endtask

  task automatic wait_done(input int prev, input string name);
    for (int i = 0; i < 400; i++) begin
      if (done_cnt != prev) break;
      @(posedge clk);
      #1;
    end
    check(name, {31'd0, done_cnt != prev}, 32'd1);
    @(posedge clk);
    #1;
    check("exp_addr_drained", exp_addr.size(), 32'd0);
  endtask

  initial begin
    int prev;
    int base_cnt;
    int n;

    // Reset state.
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rd_en", {31'd0, sc_mem_rd_en}, 32'd0);
    check("rst_rdaddr", {16'd0, sc_mem_rdaddr}, 32'd0);
    check("rst_lines", {25'd0, lines_issued}, 32'd0);
    check("rst_flags", {30'd0, aborted, err_unexp_done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Basic sequence with credit returns.
    prev = done_cnt;
    expect_seq(16'd64, 16'd2, 4, 1'b0, 4);
    start_seq(16'd64, 16'd2, 7'd4);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    wait_done(prev, "basic_done_timeout");
    check("basic_rd_count", rd_cnt, 32'd4);
    check("basic_idle", {31'd0, busy}, 32'd0);

    // Credit stall: only MAX_OUTST reads without div_done.
    prev = done_cnt;
    base_cnt = rd_cnt;
    hold = 1'b1;
    expect_seq(16'h0200, 16'h0010, 5, 1'b0, 5);
    start_seq(16'h0200, 16'h0010, 7'd5);
    repeat (20) @(posedge clk);
    #1;
    check("stall_rd_count", rd_cnt - base_cnt, 32'd2);
    check("stall_busy", {31'd0, busy}, 32'd1);
    hold = 1'b0;
    wait_done(prev, "stall_done_timeout");
    check("stall_total", rd_cnt - base_cnt, 32'd5);

    // Address wrap.
    prev = done_cnt;
    expect_seq(16'hFFFE, 16'd1, 3, 1'b0, 3);
    start_seq(16'hFFFE, 16'd1, 7'd3);
    wait_done(prev, "wrap_done_timeout");

    // Abort after the third issue.
    prev = done_cnt;
    base_cnt = rd_cnt;
    expect_seq(16'h0100, 16'd4, 3, 1'b1, 3);
    start_seq(16'h0100, 16'd4, 7'd8);
    n = 0;
    for (int i = 0; i < 100 && n < 3; i++) begin
      @(posedge clk);
      #1;
      if (sc_mem_rd_en) n++;
    end
    check("abort_reached3", n, 32'd3);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    wait_done(prev, "abort_done_timeout");
    check("abort_rd_count", rd_cnt - base_cnt, 32'd3);
    check("abort_sticky", {31'd0, aborted}, 32'd1);

    // Unexpected div_done in IDLE, then a zero-line sequence clears it.
    man_done = 1'b1;
    @(posedge clk);
    #1;
    man_done = 1'b0;
    check("err_set", {31'd0, err_unexp_done}, 32'd1);
    check("err_idle", {31'd0, busy}, 32'd0);
    prev = done_cnt;
    base_cnt = rd_cnt;
    expect_seq(16'h0, 16'h0, 0, 1'b0, 0);
    start_seq(16'h1234, 16'd1, 7'd0);
    check("err_cleared", {31'd0, err_unexp_done}, 32'd0);
    check("zero_no_done_yet", {31'd0, sc_mem_rd_done}, 32'd0);
    @(posedge clk);
    #1;
    check("zero_done_2cyc", {31'd0, sc_mem_rd_done}, 32'd1);
    wait_done(prev, "zero_done_timeout");
    check("zero_no_rd", rd_cnt - base_cnt, 32'd0);

    // Reset mid-ISSUE with two reads outstanding.
    hold = 1'b1;
    expect_seq(16'h0300, 16'd8, 2, 1'b0, 0);
    void'(exp_done.pop_back());
    base_cnt = rd_cnt;
    start_seq(16'h0300, 16'd8, 7'd8);
    repeat (6) @(posedge clk);
    #1;
    check("pre_rst_rd_count", rd_cnt - base_cnt, 32'd2);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_rdaddr", {16'd0, sc_mem_rdaddr}, 32'd0);
    check("mid_rst_lines", {25'd0, lines_issued}, 32'd0);
    check("mid_rst_flags", {29'd0, aborted, err_unexp_done, sc_mem_rd_en}, 32'd0);
    flush = 1'b1;
    hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    prev = done_cnt;
    base_cnt = rd_cnt;
    expect_seq(16'h0040, 16'h0010, 2, 1'b0, 2);
    start_seq(16'h0040, 16'h0010, 7'd2);
    check("post_rst_busy", {31'd0, busy}, 32'd1);
    wait_done(prev, "post_rst_done_timeout");
    check("post_rst_rd_count", rd_cnt - base_cnt, 32'd2);
    check("exp_done_drained", exp_done.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/divider_mem_rd_ctrl.md
DIVIDER_MEM_RD_CTRL -- requirements
Module: divider_mem_rd_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: read-address width.
REQ-002 SHALL have parameter CNT_W, default 7: line-count width.
REQ-003 SHALL have parameter MAX_OUTST, default 2, legal 1..7: maximum reads issued but not yet acknowledged by div_done.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: request a new read sequence; sampled only in IDLE.
REQ-007 SHALL have port abort, input, 1: stop issuing reads and drain the sequence.
REQ-008 SHALL have port cfg_base, input, ADDR_W: first read address.
REQ-009 SHALL have port cfg_stride, input, ADDR_W: address increment between reads.
REQ-010 SHALL have port cfg_lines, input, CNT_W: number of reads in the sequence.
REQ-011 SHALL have port div_done, input, 1: divider has consumed one read line.
REQ-012 SHALL have port sc_mem_rdaddr, output, ADDR_W: registered read address.
REQ-013 SHALL have port sc_mem_rd_en, output, 1: registered, one-cycle pulse per read.
REQ-014 SHALL have port sc_mem_rd_done, output, 1: one-cycle pulse when the sequence ends.
REQ-015 SHALL have port busy, output, 1: high whenever the state is not IDLE.
REQ-016 SHALL have port aborted, output, 1: sticky flag, set when the last sequence ended by abort.
REQ-017 SHALL have port err_unexp_done, output, 1: sticky flag, set on a div_done with no read outstanding.
REQ-018 SHALL have port lines_issued, output, CNT_W: number of reads issued in the current or last sequence.

Function
REQ-019 SHALL implement states IDLE, ISSUE, DRAIN and COMPLETE.
REQ-020 IDLE with start=1 SHALL latch cfg_base, cfg_stride and cfg_lines, clear lines_issued, aborted and err_unexp_done, and go to ISSUE; cfg changes after this latch SHALL have no effect.
REQ-021 start with latched cfg_lines=0 SHALL go ISSUE->COMPLETE with no sc_mem_rd_en pulse.
REQ-022 In ISSUE, a read SHALL issue on an edge when lines_issued<cfg_lines and outs_next<MAX_OUTST, where outs_next = outstanding - div_done.
REQ-023 Issuing a read SHALL set sc_mem_rd_en=1 for exactly one cycle and sc_mem_rdaddr = base + k*stride (k = 0-based read index), truncated to ADDR_W (modulo 2^ADDR_W wrap).
REQ-024 The first read SHALL be visible on the cycle after the ISSUE state is entered.
REQ-025 With MAX_OUTST credits available, reads SHALL issue back-to-back, one per cycle.
REQ-026 The outstanding count SHALL increment on an issue and decrement on div_done; when both occur in the same cycle the count SHALL be unchanged.
REQ-027 When lines_issued=cfg_lines, ISSUE SHALL go to DRAIN.
REQ-028 DRAIN with outstanding=0 (including outs_next=0) SHALL go to COMPLETE.
REQ-029 COMPLETE SHALL pulse sc_mem_rd_done for one cycle and return to IDLE; start SHALL be ignored in COMPLETE.
REQ-030 abort=1 in ISSUE SHALL suppress any issue in that cycle, set aborted, and go to DRAIN.
REQ-031 abort in IDLE, DRAIN or COMPLETE SHALL be ignored.
REQ-032 div_done with outstanding=0 SHALL set err_unexp_done, leave the count at 0, and not change state.
REQ-033 sc_mem_rdaddr SHALL hold its last value when sc_mem_rd_en=0.
REQ-034 Counters SHALL NOT overflow: lines_issued≤cfg_lines and outstanding≤MAX_OUTST always.

Reset
REQ-035 Assertion of reset (low) SHALL immediately force state=IDLE, all outputs 0 and all counters 0, regardless of the current state, including mid-sequence.
REQ-036 After deassertion of reset, the first start SHALL be accepted on the first rising clk edge.

Structure
REQ-037 A shared package divider_pkg SHALL hold the state encoding (2-bit) and the default parameter constants.
REQ-038 The credit counter SHALL be a sub-module divider_credit_cnt (inc, dec, count, zero, full outputs), parametrised by MAX_OUTST.
REQ-039 The FSM, address generator and issue counter SHALL reside in divider_mem_rd_ctrl.

Verification
REQ-040 base=64, stride=2, lines=4, MAX_OUTST=2, div_done each issued line 3 cycles later -> rdaddr 64,66,68,70; exactly 4 rd_en pulses; one rd_done; aborted=0.
REQ-041 lines=5, div_done withheld for 20 cycles -> exactly 2 rd_en pulses, then stall; the remaining 3 issue as credits return.
REQ-042 base=0xFFFE, stride=1, lines=3 -> rdaddr 0xFFFE, 0xFFFF, 0x0000.
REQ-043 lines=8, abort after 3rd issue -> no further rd_en; rd_done only after the outstanding count reaches 0; aborted=1; lines_issued=3.
REQ-044 div_done in IDLE -> err_unexp_done=1; the next start clears it. lines=0 -> rd_done two cycles after start, no rd_en.
REQ-045 reset asserted mid-ISSUE with 2 outstanding -> outputs 0 and busy=0 immediately without a clock; a new start then runs a clean sequence.
